// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and constants for the serial 3-bit pattern
//                detector: controller FSM encoding, pattern width and the
//                width of the detector fill counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

   // Width of the pattern being searched for
   localparam int PAT_W  = 3;

   // Fill counter counts 0..2 bits of valid history
   localparam int FILL_W = 2;

   // Fill value at which the history holds two valid bits
   localparam logic [FILL_W-1:0] c_FILL_FULL = 2'd2;

   // Controller FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_core
//  Description : Serial 3-bit pattern detector. Keeps the last two fed bits
//                and a fill counter; flags a hit when the two history bits
//                plus the current bit equal the pattern.
//                Configuration macro: PATTERN_OVERLAP_EN
//                  defined   - history is kept after a hit (overlapping
//                              matches allowed)
//                  undefined - fill is cleared on a hit, so the next match
//                              needs three fresh bits
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_core
   import seq_det_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic [PAT_W-1:0] pattern,
   input  logic             clear,
   output logic             hit
);

   logic [1:0]        r_hist;
   logic [FILL_W-1:0] r_fill;
   logic              w_full;
   logic [FILL_W-1:0] w_fill_inc;

   // A hit is only meaningful on a cycle where a bit is actually fed
   assign w_full     = (r_fill == c_FILL_FULL);
   assign hit        = bit_en && w_full && ({r_hist, bit_in} == pattern);
   assign w_fill_inc = w_full ? r_fill : (r_fill + 1'b1);

   // History shift and fill tracking; clear only forgets the fill, the stale
   // history bits are harmless because fill must reach two again
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (clear) begin
         r_fill <= '0;
      end else if (bit_en) begin
         r_hist <= {r_hist[0], bit_in};
`ifdef PATTERN_OVERLAP_EN
         r_fill <= w_fill_inc;
`else
         r_fill <= hit ? '0 : w_fill_inc;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_ctrl
//  Description : Word-level controller for the serial pattern detector.
//                Accepts a word on a valid/ready handshake, shifts it MSB
//                first into seq_det_core one bit per cycle, and returns the
//                saturating per-word match count on a second handshake.
//                Configuration macro: PATTERN_OVERLAP_EN (see seq_det_core)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_last_hit,
   output logic              busy
);

   localparam int                IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};

   state_t              r_state;
   state_t              w_next_state;
   logic [DATA_W-1:0]   r_shift;
   logic [IDX_W-1:0]    r_bit_idx;
   logic [PAT_W-1:0]    r_pattern;
   logic [CNT_W-1:0]    r_count;
   logic                r_last_hit;

   logic                w_accept;
   logic                w_bit_en;
   logic                w_clear;
   logic                w_hit;
   logic                w_final_bit;

   assign w_accept    = (r_state == ST_IDLE) && in_valid;
   assign w_final_bit = (r_bit_idx == '0);
   // Flush is ignored while a word is being scanned
   assign w_clear     = flush && (r_state != ST_SHIFT);

   assign out_count    = r_count;
   assign out_last_hit = r_last_hit;

   seq_det_core u_core (
      .clk     (clk),
      .rst     (rst),
      .bit_in  (r_shift[DATA_W-1]),
      .bit_en  (w_bit_en),
      .pattern (r_pattern),
      .clear   (w_clear),
      .hit     (w_hit)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      w_bit_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_bit_en = 1'b1;
            if (w_final_bit) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Word capture, MSB-first shifting, bit index and saturating match count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_pattern  <= '0;
         r_count    <= '0;
         r_last_hit <= 1'b0;
      end else if (w_accept) begin
         r_shift    <= in_data;
         r_pattern  <= cfg_pattern;
         r_bit_idx  <= c_IDX_LAST;
         r_count    <= '0;
         r_last_hit <= 1'b0;
      end else if (w_bit_en) begin
         r_shift <= r_shift << 1;
         if (!w_final_bit) begin
            r_bit_idx <= r_bit_idx - 1'b1;
         end
         if (w_hit && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
         end
         if (w_final_bit) begin
            r_last_hit <= w_hit;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_ctrl
//  Description : Self-checking bench for seq_det_ctrl. Expected results are
//                queued when a word is sent and compared when the result
//                handshake completes. Honours PATTERN_OVERLAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

`ifdef PATTERN_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   typedef struct {
      int cnt;
      bit last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // Main instance (DATA_W=8, CNT_W=4)
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [2:0] cfg_pattern = '0;
   logic       flush = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_count;
   logic       out_last_hit;
   logic       busy;

   // Saturation instance (CNT_W=2)
   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [7:0] s_in_data = '0;
   logic [2:0] s_cfg = '0;
   logic       s_flush = 1'b0;
   logic       s_out_valid;
   logic       s_out_ready = 1'b0;
   logic [1:0] s_out_count;
   logic       s_out_last_hit;
   logic       s_busy;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic [1:0] m_hist = '0;
   int         m_fill = 0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .cfg_pattern(cfg_pattern), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .out_last_hit(out_last_hit), .busy(busy)
   );

   seq_det_ctrl #(.DATA_W(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .cfg_pattern(s_cfg), .flush(s_flush),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_count(s_out_count),
      .out_last_hit(s_out_last_hit), .busy(s_busy)
   );

   // Reference detector: walks a word MSB first with its own history
   task automatic model_word(input logic [7:0] w, input logic [2:0] p,
                             output int c, output bit last);
      bit h;
      bit b;
      c    = 0;
      last = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         b = w[i];
         h = (m_fill == 2) && ({m_hist, b} == p);
         m_hist = {m_hist[0], b};
         if (OVL) m_fill = (m_fill == 2) ? 2 : m_fill + 1;
         else     m_fill = h ? 0 : ((m_fill == 2) ? 2 : m_fill + 1);
         if (h && c < 15) c++;
         if (i == 0) last = h;
      end
   endtask

   task automatic send_word(input logic [7:0] d, input logic [2:0] p);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready got=%b exp=1", in_ready);
      end
      in_valid    = 1'b1;
      in_data     = d;
      cfg_pattern = p;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic get_result(output int cnt, output bit last, output bit ok);
      int n = 0;
      ok   = 1'b0;
      cnt  = -1;
      last = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (out_valid === 1'b1) begin
         ok   = 1'b1;
         cnt  = int'(out_count);
         last = out_last_hit;
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #10;
      checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_count !== 4'd0)    begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
      checks++; if (out_last_hit !== 1'b0) begin errors++; $display("FAIL reset_last_hit got=%b exp=0", out_last_hit); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_overlap();
      int c; bit l; bit ok; exp_t e;
      sb.push_back('{OVL ? 3 : 2, 1'b0});
      send_word(8'b1010_1010, 3'b101);
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL overlap_busy got=%b exp=1", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL overlap_in_ready got=%b exp=0", in_ready); end
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL overlap_count got=%0d exp=%0d", c, e.cnt); end
      checks++; if (l !== e.last)      begin errors++; $display("FAIL overlap_last got=%b exp=%b", l, e.last); end
   endtask

   task automatic test_span();
      int c; bit l; bit ok; exp_t e;
      do_flush();
      sb.push_back('{0, 1'b0});
      sb.push_back('{1, 1'b0});
      send_word(8'b0000_0010, 3'b101);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL span_w1_count got=%0d exp=%0d", c, e.cnt); end
      send_word(8'b1000_0000, 3'b101);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL span_w2_count got=%0d exp=%0d", c, e.cnt); end
      // Same sequence with a flush between the words
      do_flush();
      sb.push_back('{0, 1'b0});
      sb.push_back('{0, 1'b0});
      send_word(8'b0000_0010, 3'b101);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL span_fl_w1_count got=%0d exp=%0d", c, e.cnt); end
      do_flush();
      send_word(8'b1000_0000, 3'b101);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL span_fl_w2_count got=%0d exp=%0d", c, e.cnt); end
   endtask

   task automatic test_last_hit();
      int c; bit l; bit ok; exp_t e;
      do_flush();
      sb.push_back('{1, 1'b1});
      send_word(8'b0000_0110, 3'b110);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL lasthit_count got=%0d exp=%0d", c, e.cnt); end
      checks++; if (l !== e.last)      begin errors++; $display("FAIL lasthit_last got=%b exp=%b", l, e.last); end
   endtask

   task automatic test_saturate();
      int n = 0; exp_t e;
      sb.push_back('{OVL ? 3 : 2, OVL});
      @(negedge clk);
      checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready got=%b exp=1", s_in_ready); end
      s_in_valid = 1'b1;
      s_in_data  = 8'h00;
      s_cfg      = 3'b000;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      @(negedge clk);
      while (!s_out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      checks++; if (s_out_valid !== 1'b1 || int'(s_out_count) != e.cnt) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", s_out_count, e.cnt); end
      checks++; if (s_out_last_hit !== e.last) begin errors++; $display("FAIL sat_last got=%b exp=%b", s_out_last_hit, e.last); end
      s_out_ready = 1'b1;
      @(posedge clk);
      #1 s_out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n = 0; int c0; bit l0; exp_t e;
      do_flush();
      sb.push_back('{OVL ? 3 : 2, 1'b0});
      send_word(8'b1010_1010, 3'b101);
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      c0 = int'(out_count);
      l0 = out_last_hit;
      e  = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || c0 != e.cnt) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", c0, e.cnt); end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         checks++;
         if (out_valid !== 1'b1 || int'(out_count) != e.cnt || out_last_hit !== e.last || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got v=%b c=%0d l=%b r=%b exp v=1 c=%0d l=%b r=0",
                     k, out_valid, out_count, out_last_hit, in_ready, e.cnt, e.last);
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_not_accepted got ready=%b busy=%b exp ready=1 busy=0", in_ready, busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midword();
      int c; bit l; bit ok; exp_t e;
      do_flush();
      send_word(8'b0110_1111, 3'b101);
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst = 1'b1;
      // History "10" was fed before reset; an empty history must not match
      sb.push_back('{0, 1'b0});
      send_word(8'b1000_0000, 3'b101);
      get_result(c, l, ok);
      e = sb.pop_front();
      checks++; if (!ok || c != e.cnt) begin errors++; $display("FAIL midrst_next_count got=%0d exp=%0d", c, e.cnt); end
   endtask

   task automatic test_back_to_back();
      int c; bit l; bit ok; exp_t e; int ec; bit el;
      logic [7:0] d; logic [2:0] p;
      do_flush();
      m_fill = 0;
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom);
         p = 3'($urandom_range(0, 7));
         model_word(d, p, ec, el);
         sb.push_back('{ec, el});
         send_word(d, p);
         get_result(c, l, ok);
         e = sb.pop_front();
         checks++;
         if (!ok || c != e.cnt || l !== e.last) begin
            errors++;
            $display("FAIL b2b word=%02h pat=%03b got c=%0d l=%b exp c=%0d l=%b", d, p, c, l, e.cnt, e.last);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_span();
      test_last_hit();
      test_saturate();
      test_backpressure();
      test_reset_midword();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
